// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction-fetch stage feeding the decoder.
//
// Owns the program counter, issues one word fetch at a time over a
// req/gnt/rvalid memory port, and hands each fetched instruction plus its PC
// to decode through a registered valid/stall interface. A one-entry skid
// buffer absorbs the single response that can land while decode is stalled.
// Redirects from execute (taken branch/jump) flush the output and skid
// buffer and squash any fetch that is already in flight.
//
// Ports
//   clk_i          clock; all state changes on the rising edge
//   rst_i          synchronous, active-high reset
//   pc_set_i       redirect request from execute
//   pc_target_i    redirect target; bits [1:0] are forced to zero
//   stall_i        decode cannot accept; hold instr_valid_o/instr_o/pc_o
//   instr_req_o    memory request (decoded from FSM state)
//   instr_addr_o   word-aligned request address (decoded from state/PC)
//   instr_gnt_i    request accepted this cycle
//   instr_rvalid_i response data valid
//   instr_rdata_i  response data
//   instr_valid_o  instr_o/pc_o hold a valid instruction
//   instr_o        instruction to decode (NOP_INSTR when nothing is valid)
//   pc_o           PC of instr_o
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pc_set_i,
  input  logic [31:0] pc_target_i,
  input  logic        stall_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // no request; waiting for the skid buffer to drain
    S_REQ  = 2'd1,  // request on the bus, waiting for grant
    S_WAIT = 2'd2   // request granted, waiting for the response
  } state_e;

  state_e      state_q, state_d;

  // Program counter: address of the next request to be issued.
  logic [31:0] pc_q, pc_d;

  // PC of the granted request whose response is outstanding. While a killed
  // request is still waiting for grant it instead holds that request's old
  // address, so the bus address stays stable across the redirect.
  logic [31:0] fetch_pc_q, fetch_pc_d;

  // Set while exactly one squashed fetch is still owed a response.
  logic        kill_q, kill_d;

  // Output register towards decode.
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;

  // One-entry skid buffer for a response that lands while decode stalls.
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic        grant;
  logic        resp_arrive;
  logic        resp_live;
  logic [31:0] redirect_pc;

  // Handshake qualifiers. A response only counts in S_WAIT; anything seen in
  // IDLE or REQ belongs to no request of ours and is ignored.
  assign grant       = (state_q == S_REQ) && instr_gnt_i;
  assign resp_arrive = (state_q == S_WAIT) && instr_rvalid_i;
  // A response reaches decode only if it was not squashed earlier and is not
  // being squashed by a redirect in this very cycle.
  assign resp_live   = resp_arrive && !kill_q && !pc_set_i;
  assign redirect_pc = pc_target_i & 32'hFFFF_FFFC;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written in this block gets a default first so that
    // no path leaves it unassigned, which would infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_pc_d   = fetch_pc_q;
    kill_d       = kill_q;
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    // ---- Output register and skid buffer --------------------------------
    if (pc_set_i) begin
      // Redirect beats stall and any same-cycle response: everything held
      // downstream of the PC is on the wrong path.
      out_valid_d  = 1'b0;
      out_instr_d  = NOP_INSTR;
      skid_valid_d = 1'b0;
    end else if (resp_live) begin
      if (!out_valid_q || !stall_i) begin
        out_valid_d = 1'b1;
        out_instr_d = instr_rdata_i;
        out_pc_d    = fetch_pc_q;
      end else begin
        // Decode is holding a valid instruction; park the new one.
        skid_valid_d = 1'b1;
        skid_instr_d = instr_rdata_i;
        skid_pc_d    = fetch_pc_q;
      end
    end else if (!stall_i) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_instr_d  = skid_instr_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b0;
        out_instr_d = NOP_INSTR;
      end
    end

    // ---- Program counter and kill flag ----------------------------------
    // A grant of a request that was already squashed must not advance the
    // PC: that request was for the old path.
    if (grant && !kill_q) begin
      fetch_pc_d = pc_q;
      pc_d       = pc_q + 32'd4;
    end

    // Any response arriving in WAIT settles the outstanding request, which
    // is also the only one the kill flag can refer to.
    if (resp_arrive) begin
      kill_d = 1'b0;
    end

    if (pc_set_i) begin
      pc_d = redirect_pc;
      unique case (state_q)
        S_REQ: begin
          // The request on the bus is abandoned but must still complete.
          // If it is not granted now, remember its address so the bus keeps
          // showing it; a request already killed keeps its saved address.
          kill_d = 1'b1;
          if (!instr_gnt_i && !kill_q) begin
            fetch_pc_d = pc_q;
          end
        end
        S_WAIT: begin
          // A same-cycle response is simply dropped; otherwise remember to
          // drop it when it arrives.
          kill_d = !instr_rvalid_i;
        end
        default: begin
          kill_d = kill_q;
        end
      endcase
    end

    // ---- FSM ------------------------------------------------------------
    unique case (state_q)
      S_IDLE: begin
        if (pc_set_i || !skid_valid_q) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (instr_gnt_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Do not start a new fetch while its result would have nowhere to
        // go: the skid buffer is the last free slot.
        if (instr_rvalid_i) begin
          state_d = skid_valid_d ? S_IDLE : S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every flop samples the values from
    // before this edge, independent of statement order.
    if (rst_i) begin
      state_q      <= S_IDLE;
      pc_q         <= BOOT_ADDR;
      fetch_pc_q   <= BOOT_ADDR;
      kill_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= NOP_INSTR;
      out_pc_q     <= 32'h0000_0000;
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_pc_q   <= fetch_pc_d;
      kill_q       <= kill_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // REQ with the kill flag set only happens when a redirect hit an ungranted
  // request; the bus must keep that request's address until it is granted.
  assign instr_req_o   = (state_q == S_REQ);
  assign instr_addr_o  = (state_q == S_REQ && kill_q) ? fetch_pc_q : pc_q;

  assign instr_valid_o = out_valid_q;
  assign instr_o       = out_instr_q;
  assign pc_o          = out_pc_q;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
//
// A small instruction-memory model answers requests with a configurable
// grant delay and response latency. Each delivered response pushes its
// expected {pc, instr} into a scoreboard queue; every instruction consumed by
// decode (valid and not stalled) is popped and compared. Redirects and resets
// purge the queue and mark in-flight responses as squashed. Directed checks
// cover reset values, bus timing, stall/skid behaviour, redirects and PC wrap.
// ---------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        pc_set_i;
  logic [31:0] pc_target_i;
  logic        stall_i;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  if_stage dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .pc_set_i       (pc_set_i),
    .pc_target_i    (pc_target_i),
    .stall_i        (stall_i),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_valid_o  (instr_valid_o),
    .instr_o        (instr_o),
    .pc_o           (pc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          gnt_cyc  = 0;

  // Memory model state.
  int          gnt_delay       = 0;
  int          rvalid_delay    = 1;
  int          wait_cnt        = 0;
  bit          pend            = 1'b0;
  bit          pend_kill       = 1'b0;
  int          pend_cnt        = 0;
  logic [31:0] pend_addr       = 32'h0;
  bit          kill_next_grant = 1'b0;
  bit          last_gnt        = 1'b0;
  bit          prev_req_wait   = 1'b0;
  logic [31:0] prev_addr       = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0) return 32'h0010_0093;
    if (addr == 32'h4) return 32'h0020_0113;
    return addr ^ 32'h5A00_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock cycle, entered and left at a falling edge. Checks the outputs
  // seen this cycle, drives the memory side, then updates the model.
  task automatic cycle();
    bit          gnt_now;
    bit          rv_now;
    bit          grant_kill;
    bit          req_s;
    logic [31:0] addr_s;
    exp_t        e;

    req_s  = instr_req_o;
    addr_s = instr_addr_o;

    if (!rst_i && prev_req_wait) check("addr_stable", addr_s, prev_addr);

    if (!rst_i) begin
      if (instr_valid_o) begin
        if (!stall_i) begin
          if (sb_q.size() == 0) begin
            check("sb_unexpected_valid", {31'b0, instr_valid_o}, 32'h0);
          end else begin
            e = sb_q.pop_front();
            check("sb_pc", pc_o, e.pc);
            check("sb_instr", instr_o, e.instr);
          end
        end
      end else begin
        check("idle_nop", instr_o, NOP);
      end
    end

    gnt_now = req_s && !rst_i && (wait_cnt >= gnt_delay);
    rv_now  = pend && (pend_cnt == 0);
    instr_gnt_i    = gnt_now;
    instr_rvalid_i = rv_now;
    instr_rdata_i  = rv_now ? mem_word(pend_addr) : 32'h0;

    grant_kill = kill_next_grant || (pc_set_i && gnt_now);
    if (gnt_now) kill_next_grant = 1'b0;

    if (rv_now && !(pend_kill || pc_set_i || rst_i)) begin
      sb_q.push_back('{pc: pend_addr, instr: mem_word(pend_addr)});
    end

    if (pc_set_i && !rst_i) begin
      sb_q.delete();
      if (!rv_now) begin
        if (pend) pend_kill = 1'b1;
        else if (req_s && !gnt_now) kill_next_grant = 1'b1;
      end
    end

    if (rst_i) begin
      sb_q.delete();
      kill_next_grant = 1'b0;
      pend_kill       = 1'b1;
    end

    prev_req_wait = req_s && !gnt_now && !rst_i;
    prev_addr     = addr_s;
    if (gnt_now) gnt_cyc = cyc;

    @(posedge clk_i);
    cyc++;
    if (rv_now) pend = 1'b0;
    else if (pend) pend_cnt--;
    if (gnt_now) begin
      pend      = 1'b1;
      pend_cnt  = rvalid_delay - 1;
      pend_addr = addr_s;
      pend_kill = grant_kill;
      wait_cnt  = 0;
    end else if (req_s && !rst_i) begin
      wait_cnt++;
    end
    if (rst_i) wait_cnt = 0;
    last_gnt = gnt_now;
    @(negedge clk_i);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 60 && !instr_valid_o; i++) cycle();
    if (!instr_valid_o) check("timeout_valid", {31'b0, instr_valid_o}, 32'h1);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 60 && !instr_req_o; i++) cycle();
    if (!instr_req_o) check("timeout_req", {31'b0, instr_req_o}, 32'h1);
  endtask

  task automatic wait_gnt();
    last_gnt = 1'b0;
    for (int i = 0; i < 60 && !last_gnt; i++) cycle();
    if (!last_gnt) check("timeout_gnt", {31'b0, instr_req_o}, 32'h1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'b0, instr_req_o},   32'h0);
    check({tag, "_addr"},  instr_addr_o,           32'h0);
    check({tag, "_valid"}, {31'b0, instr_valid_o}, 32'h0);
    check({tag, "_instr"}, instr_o,                NOP);
    check({tag, "_pc"},    pc_o,                   32'h0);
  endtask

  initial begin
    rst_i          = 1'b1;
    pc_set_i       = 1'b0;
    pc_target_i    = 32'h0;
    stall_i        = 1'b0;
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = 32'h0;
    @(negedge clk_i);

    // ---- 1: reset, zero-wait fetch of two instructions --------------------
    cycle();
    cycle();
    check_reset_outputs("rst");
    rst_i = 1'b0;
    cycle();
    check("first_req", {31'b0, instr_req_o}, 32'h1);
    check("first_addr", instr_addr_o, 32'h0);
    wait_valid();
    check("first_latency", cyc - gnt_cyc, 32'd2);
    check("first_instr", instr_o, 32'h0010_0093);
    check("first_pc", pc_o, 32'h0);
    cycle();
    wait_valid();
    check("second_instr", instr_o, 32'h0020_0113);
    check("second_pc", pc_o, 32'h4);

    // ---- 2: grant delayed by 3 cycles on the request for 0x8 --------------
    gnt_delay = 3;
    for (int k = 0; k < 4; k++) begin
      check("dly_req", {31'b0, instr_req_o}, 32'h1);
      check("dly_addr", instr_addr_o, 32'h8);
      check("dly_pc_q", dut.pc_q, 32'h8);
      cycle();
    end
    check("dly_pc_q_after", dut.pc_q, 32'hC);
    gnt_delay = 0;

    // ---- 3: 5-cycle stall with one response into the skid buffer ----------
    rst_i = 1'b1;
    cycle();
    cycle();
    rst_i = 1'b0;
    wait_valid();
    cycle();
    wait_valid();
    stall_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("stall_pc", pc_o, 32'h4);
      check("stall_valid", {31'b0, instr_valid_o}, 32'h1);
      if (k >= 2) begin
        check("stall_noreq", {31'b0, instr_req_o}, 32'h0);
        check("stall_skid_full", {31'b0, dut.skid_valid_q}, 32'h1);
      end
      cycle();
    end
    stall_i = 1'b0;
    cycle();
    check("unstall_valid", {31'b0, instr_valid_o}, 32'h1);
    check("unstall_pc", pc_o, 32'h8);
    check("unstall_skid_empty", {31'b0, dut.skid_valid_q}, 32'h0);
    cycle();
    check("unstall_req", {31'b0, instr_req_o}, 32'h1);
    check("unstall_addr", instr_addr_o, 32'hC);

    // ---- 4: redirect during WAIT --------------------------------------
    rvalid_delay = 3;
    wait_gnt();
    pc_set_i    = 1'b1;
    pc_target_i = 32'h0000_0103;
    cycle();
    pc_set_i    = 1'b0;
    pc_target_i = 32'h0;
    rvalid_delay = 1;
    check("redir_wait_valid", {31'b0, instr_valid_o}, 32'h0);
    wait_req();
    check("redir_wait_addr", instr_addr_o, 32'h100);
    wait_valid();
    check("redir_wait_pc", pc_o, 32'h100);
    check("redir_wait_instr", instr_o, mem_word(32'h100));

    // ---- 5: redirect + stall + rvalid in one cycle ------------------------
    stall_i = 1'b1;
    cycle();
    pc_set_i    = 1'b1;
    pc_target_i = 32'h0000_0200;
    cycle();
    pc_set_i    = 1'b0;
    pc_target_i = 32'h0;
    check("same_valid", {31'b0, instr_valid_o}, 32'h0);
    check("same_instr", instr_o, NOP);
    check("same_skid", {31'b0, dut.skid_valid_q}, 32'h0);
    check("same_req", {31'b0, instr_req_o}, 32'h1);
    check("same_addr", instr_addr_o, 32'h200);
    stall_i = 1'b0;

    // ---- 6: PC wrap, then reset while in WAIT ----------------------------
    pc_set_i    = 1'b1;
    pc_target_i = 32'hFFFF_FFFC;
    cycle();
    pc_set_i    = 1'b0;
    pc_target_i = 32'h0;
    wait_req();
    check("wrap_addr0", instr_addr_o, 32'hFFFF_FFFC);
    wait_gnt();
    wait_req();
    check("wrap_addr1", instr_addr_o, 32'h0);
    rvalid_delay = 3;
    wait_gnt();
    rst_i = 1'b1;
    cycle();
    check_reset_outputs("midrst");
    check("midrst_pc_q", dut.pc_q, 32'h0);
    cycle();
    rst_i = 1'b0;
    rvalid_delay = 1;
    cycle();
    check("post_rst_req", {31'b0, instr_req_o}, 32'h1);
    check("post_rst_addr", instr_addr_o, 32'h0);
    wait_valid();
    check("post_rst_pc", pc_o, 32'h0);
    check("post_rst_instr", instr_o, 32'h0010_0093);
    for (int k = 0; k < 6; k++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage, directly upstream of the decoder/control unit.
- Owns the program counter and drives a req/gnt/rvalid instruction-memory port.
- Presents one fetched instruction plus its PC to decode through a valid/stall interface.
- Supports redirects (jump/branch) with squashing of in-flight fetches and a 1-entry skid buffer for decode backpressure.

Parameters:
- BOOT_ADDR, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013 (addi x0,x0,0), value driven on instr_o when no valid instruction is held.

Ports:
- clk_i  in  1  clock. Single clock domain: all state updates on the rising edge of clk_i.
- rst_i  in  1  reset. Synchronous, active-high.
- pc_set_i  in  1  redirect request from execute (taken branch/jump).
- pc_target_i  in  32  redirect target; bits [1:0] are ignored and treated as 0.
- stall_i  in  1  decode cannot accept; hold the current output.
- instr_req_o  out  1  memory request.
- instr_addr_o  out  32  request address, word aligned.
- instr_gnt_i  in  1  request accepted this cycle.
- instr_rvalid_i  in  1  response data valid.
- instr_rdata_i  in  32  response data.
- instr_valid_o  out  1  instr_o/pc_o hold a valid instruction.
- instr_o  out  32  instruction to decode.
- pc_o  out  32  PC of instr_o.

Behaviour:
- Reset values:
  - pc_q = BOOT_ADDR; FSM = IDLE.
  - instr_req_o = 0; instr_addr_o = BOOT_ADDR.
  - instr_valid_o = 0; instr_o = NOP_INSTR; pc_o = 0.
  - Skid buffer empty; kill flag clear.
- Reset asserted mid-operation: same values on the next edge. Any rvalid arriving while in IDLE is ignored.
- FSM states and transitions:
  - IDLE: go to REQ when the skid buffer is empty; otherwise stay.
  - REQ: instr_req_o = 1, instr_addr_o = pc_q. Go to WAIT on instr_gnt_i.
  - WAIT: instr_req_o = 0. On instr_rvalid_i, go to REQ if the skid buffer will be empty next cycle, else IDLE.
- Memory protocol:
  - instr_addr_o must stay stable while req is high and gnt is low.
  - At most one outstanding request.
  - Zero-wait memory (gnt in REQ, rvalid the next cycle) gives one instruction per 2 cycles.
- PC update:
  - On gnt, pc_q <= pc_q + 4, wrapping modulo 2^32 (0xFFFF_FFFC -> 0).
  - The PC of the granted request is saved as the fetch PC for the response.
- Response delivery, on rvalid with kill flag clear:
  - Output register empty, or output valid with stall_i = 0: load instr_o/pc_o and set instr_valid_o = 1 at that edge.
  - Output valid with stall_i = 1: write the response into the skid buffer.
- Output update when stall_i = 0 and no new response:
  - Skid buffer full: move it to the output register.
  - Otherwise: clear instr_valid_o and drive instr_o = NOP_INSTR.
- Stall hold: while stall_i = 1, instr_o, pc_o and instr_valid_o are unchanged.
- Redirect (pc_set_i = 1):
  - Redirect wins over stall and over a same-cycle rvalid.
  - Next edge: instr_valid_o = 0, instr_o = NOP_INSTR, skid buffer cleared, pc_q <= {pc_target_i[31:2], 2'b00}.
  - In IDLE: go to REQ.
  - In REQ without gnt: the request stays on the old address until granted (kill flag set). Its response is discarded; then REQ with the new pc_q.
  - In REQ with gnt in the same cycle: kill flag set; pc_q takes the target, not +4.
  - In WAIT without rvalid: kill flag set; the response is discarded on arrival and the FSM goes to REQ.
  - In WAIT with rvalid in the same cycle: the response is dropped; go to REQ.
  - Kill flag clears when the killed response arrives.
  - Back-to-back redirects: the last target wins. At most one killed response is pending.
- Outputs are registered except instr_req_o and instr_addr_o, which are decoded from FSM state and pc_q.

Test Plan:
- Reset release, zero-wait memory returning 0x00100093 then 0x00200113 -> req in cycle 1 at addr 0x0; instr_valid_o=1, instr_o=0x00100093, pc_o=0x0 two cycles after grant; second fetch at addr 0x4, pc_o=0x4.
- gnt delayed 3 cycles -> instr_addr_o stable at 0x8 for all 4 req cycles; pc_q becomes 0xC only after gnt.
- stall_i high for 5 cycles with one response arriving -> output holds pc_o=0x4; response goes to the skid buffer; no new req; after stall drops, pc_o=0x8 next cycle, then req for 0xC.
- pc_set_i=1, pc_target_i=0x0000_0103 during WAIT -> outstanding response discarded; next req addr=0x100; first valid output pc_o=0x100; no instr_valid_o for the killed instruction.
- Same-cycle pc_set_i, stall_i and rvalid -> next cycle instr_valid_o=0, instr_o=0x00000013, skid empty, req to target.
- PC wrap: redirect to 0xFFFF_FFFC, fetch two instructions -> second req addr=0x0000_0000; rst_i asserted while in WAIT -> next cycle all outputs at reset values, pc restarts at BOOT_ADDR.
